ram: RTL and testbench

//  Byte-addressed, little-endian data memory for the single-cycle RISC-V core.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/ram_if.sv | 36 +++
 rtl/ram_lane_ctrl.sv | 36 +++
 rtl/ram.sv | 66 ++++++
 tb/tb_ram.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the data memory.
//   Contents:
//     MEM_BYTE / MEM_HALF / MEM_WORD : encodings of the mem_ctrl access size
//     size_bytes(mem_ctrl)           : number of bytes an access touches (1/2/4)
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    // Encoding 3 is not a distinct size; it is treated as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] mem_ctrl);
        case (mem_ctrl)
            MEM_BYTE: size_bytes = 3'd1;
            MEM_HALF: size_bytes = 3'd2;
            default:  size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_if.sv
// -----------------------------------------------------------------------------
// ram_if
//   Load/store bus between the core and the data memory.
//   Signals:
//     we        : 1 = store, 0 = load
//     mem_ctrl  : access size (byte / half / word, 3 = word)
//     address   : byte address
//     data_in   : store data, LSB-aligned for byte/half
//     data_out  : load data, zero-extended
//   Modports: master (core side), slave (memory side).
// -----------------------------------------------------------------------------
interface ram_if;

    logic        we;
    logic [1:0]  mem_ctrl;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output we,
        output mem_ctrl,
        output address,
        output data_in,
        input  data_out
    );

    modport slave (
        input  we,
        input  mem_ctrl,
        input  address,
        input  data_in,
        output data_out
    );

endinterface

// File: rtl/ram_lane_ctrl.sv
// -----------------------------------------------------------------------------
// ram_lane_ctrl
//   Maps a byte index and access size onto four byte lanes.
//   Lane k addresses mem[(idx + k) mod DEPTH] and carries data bits [8k+7:8k].
//   Ports:
//     addr_i     : byte index (already truncated to AW bits)
//     mem_ctrl_i : access size
//     idx_o      : per-lane byte index, wrapping at the top of memory
//     en_o       : per-lane enable, set for lanes below the access size
// -----------------------------------------------------------------------------
module ram_lane_ctrl
    import mem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [AW-1:0]       addr_i,
    input  logic [1:0]          mem_ctrl_i,
    output logic [3:0][AW-1:0]  idx_o,
    output logic [3:0]          en_o
);

    logic [2:0] nbytes;

    assign nbytes = size_bytes(mem_ctrl_i);

    // DEPTH is a power of two, so AW-bit addition wraps modulo DEPTH for free.
    always_comb begin
        idx_o = '0;
        en_o  = '0;
        for (int k = 0; k < 4; k++) begin
            idx_o[k] = addr_i + AW'(k);
            en_o[k]  = (3'(k) < nbytes);
        end
    end

endmodule

// File: rtl/ram.sv
// -----------------------------------------------------------------------------
// ram
//   Byte-addressed little-endian data memory for the single-cycle core.
//   Stores commit on the rising clock edge; loads are combinational and
//   zero-extended. Misaligned accesses are legal and wrap at the top.
//   Ports:
//     clk    : clock, stores on rising edge
//     rst_n  : asynchronous active-low reset, clears every byte
//     bus    : ram_if.slave (we, mem_ctrl, address, data_in, data_out)
// -----------------------------------------------------------------------------
module ram #(
    parameter int DEPTH_BYTES = 256
) (
    input  logic  clk,
    input  logic  rst_n,
    ram_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0]          mem_q [DEPTH_BYTES];
    logic [3:0][AW-1:0]  lane_idx;
    logic [3:0]          lane_en;
    logic [31:0]         rdata;

    // Upper address bits alias onto the array and are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.address[31:AW];

    ram_lane_ctrl #(
        .AW (AW)
    ) u_lane_ctrl (
        .addr_i     (bus.address[AW-1:0]),
        .mem_ctrl_i (bus.mem_ctrl),
        .idx_o      (lane_idx),
        .en_o       (lane_en)
    );

    // Storage: cleared asynchronously, byte lanes written on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (bus.we) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem_q[lane_idx[k]] <= bus.data_in[8*k +: 8];
                end
            end
        end
    end

    // Read mux: disabled lanes read as zero, giving zero extension.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) begin
                rdata[8*k +: 8] = mem_q[lane_idx[k]];
            end
        end
    end

    assign bus.data_out = rdata;

endmodule

// File: tb/tb_ram.sv
// -----------------------------------------------------------------------------
// tb_ram
//   Directed testbench for ram with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_ram;
    import mem_pkg::*;

    localparam int DEPTH = 256;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    ram_if bus ();

    ram #(
        .DEPTH_BYTES (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One store: inputs set after the falling edge, committed on the next rising edge.
    task automatic store(input logic [1:0] ctrl, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.we       = 1'b1;
        bus.mem_ctrl = ctrl;
        bus.address  = addr;
        bus.data_in  = data;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic load(input string tag, input logic [1:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] exp);
        bus.we       = 1'b0;
        bus.mem_ctrl = ctrl;
        bus.address  = addr;
        #1;
        check(tag, bus.data_out, exp);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b1;
        bus.we       = 1'b0;
        bus.mem_ctrl = MEM_WORD;
        bus.address  = '0;
        bus.data_in  = '0;

        // 1) Reset clears everything
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int a = 0; a <= DEPTH - 4; a += 4) begin
            load("reset_sweep", MEM_WORD, 32'(a), 32'h0000_0000);
        end

        // 2) Mixed stores
        store(MEM_BYTE, 32'd4,  32'h1234_5678);
        store(MEM_BYTE, 32'd5,  32'h1234_5678);
        store(MEM_BYTE, 32'd6,  32'h1234_5678);
        store(MEM_HALF, 32'd4,  32'h1234_5678);
        store(MEM_HALF, 32'd5,  32'h1234_5678);
        store(MEM_WORD, 32'd12, 32'h1234_5678);
        load("word@0",  MEM_WORD, 32'd0,  32'h0000_0000);
        load("word@4",  MEM_WORD, 32'd4,  32'h0056_7878);
        load("word@8",  MEM_WORD, 32'd8,  32'h0000_0000);
        load("word@12", MEM_WORD, 32'd12, 32'h1234_5678);

        // 3) Sized loads
        load("byte@12", MEM_BYTE, 32'd12, 32'h0000_0078);
        load("half@13", MEM_HALF, 32'd13, 32'h0000_3456);
        load("byte@6",  MEM_BYTE, 32'd6,  32'h0000_0056);
        load("ctrl3@12", 2'd3,    32'd12, 32'h1234_5678);

        // 4) Wrap from top of memory to 0
        store(MEM_WORD, 32'(DEPTH - 2), 32'hAABB_CCDD);
        load("wrap_b0", MEM_BYTE, 32'(DEPTH - 2), 32'h0000_00DD);
        load("wrap_b1", MEM_BYTE, 32'(DEPTH - 1), 32'h0000_00CC);
        load("wrap_b2", MEM_BYTE, 32'd0,          32'h0000_00BB);
        load("wrap_b3", MEM_BYTE, 32'd1,          32'h0000_00AA);
        load("wrap_word", MEM_WORD, 32'(DEPTH - 2), 32'hAABB_CCDD);

        // mem_ctrl=3 stores as a word
        store(2'd3, 32'd32, 32'h1122_3344);
        load("ctrl3_word", MEM_WORD, 32'd32, 32'h1122_3344);
        load("ctrl3_top",  MEM_BYTE, 32'd35, 32'h0000_0011);

        // Read during write: old contents before the edge, new after
        @(negedge clk);
        bus.we       = 1'b1;
        bus.mem_ctrl = MEM_WORD;
        bus.address  = 32'd20;
        bus.data_in  = 32'hDEAD_BEEF;
        #1 check("rdw_before", bus.data_out, 32'h0000_0000);
        @(posedge clk);
        #1 check("rdw_after", bus.data_out, 32'hDEAD_BEEF);
        bus.we = 1'b0;

        // 5) we=0 with toggling data leaves memory unchanged
        bus.mem_ctrl = MEM_WORD;
        bus.address  = 32'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.data_in = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            @(posedge clk);
        end
        #1;
        load("hold@4",  MEM_WORD, 32'd4,  32'h0056_7878);
        load("hold@12", MEM_WORD, 32'd12, 32'h1234_5678);

        // Async reset between edges takes effect immediately
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_clr@12", bus.data_out, 32'h0000_0000);
        load("async_clr@top", MEM_WORD, 32'(DEPTH - 2), 32'h0000_0000);

        // No store while reset is held
        bus.we       = 1'b1;
        bus.mem_ctrl = MEM_WORD;
        bus.address  = 32'd40;
        bus.data_in  = 32'h5555_5555;
        @(posedge clk);
        #1 bus.we = 1'b0;
        rst_n = 1'b1;
        load("no_store_in_reset", MEM_WORD, 32'd40, 32'h0000_0000);

        // 6) Aliasing of upper address bits
        store(MEM_WORD, 32'(DEPTH + 8), 32'hCAFE_F00D);
        load("alias@8", MEM_WORD, 32'd8, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
